// File: rtl/had_trace_cnt_if.sv
// Trace-step counter bus: HAD control/upstream side (master) to the
// trace counter (slave). Carries control, write port, retire pulse,
// debug handshake and read-back.
interface had_trace_cnt_if #(parameter int CNT_WIDTH = 8);
  logic                 trace_en;
  logic                 trace_cnt_wen;
  logic [CNT_WIDTH-1:0] trace_cnt_wdata;
  logic                 trace_retire_vld;
  logic                 iu_yy_xx_dbgon;
  logic                 trace_dbg_req;
  logic [CNT_WIDTH-1:0] trace_cnt_value;
  logic                 trace_cnt_zero;

  modport master (
    output trace_en, trace_cnt_wen, trace_cnt_wdata, trace_retire_vld,
           iu_yy_xx_dbgon,
    input  trace_dbg_req, trace_cnt_value, trace_cnt_zero
  );

  modport slave (
    input  trace_en, trace_cnt_wen, trace_cnt_wdata, trace_retire_vld,
           iu_yy_xx_dbgon,
    output trace_dbg_req, trace_cnt_value, trace_cnt_zero
  );
endinterface

// File: rtl/had_trace_cnt.sv
// HAD trace-step counter. Counts qualified retire pulses down from a
// CSR-loaded value and raises a debug request when the count expires,
// holding it until the core reports debug mode.
// Optional: HAD_TRACE_AUTO_RELOAD_EN keeps a copy of the last written
// count and reloads it on expiry so back-to-back trace stops need no
// software rewrite.
module had_trace_cnt #(
  parameter int CNT_WIDTH = 8
) (
  input  logic          cpuclk,
  input  logic          cpurst,
  had_trace_cnt_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COUNT, REQ, DBG} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] expire_val;
  logic                 req_q;
  logic                 take;
  logic                 expire;

  // A retire counts only while actively counting; a write the same cycle
  // wins and a debug entry from elsewhere suppresses it.
  assign take   = bus.trace_en && (state == COUNT) && !bus.iu_yy_xx_dbgon &&
                  bus.trace_retire_vld && !bus.trace_cnt_wen;
  // Counts of 0 and 1 both expire on this retire.
  assign expire = take && (cnt <= CNT_WIDTH'(1));

`ifdef HAD_TRACE_AUTO_RELOAD_EN
  logic [CNT_WIDTH-1:0] reload;

  // Shadow of the last software-written count.
  always_ff @(posedge cpuclk or posedge cpurst) begin
    if (cpurst)                 reload <= '0;
    else if (bus.trace_cnt_wen) reload <= bus.trace_cnt_wdata;
  end

  assign expire_val = reload;
`else
  assign expire_val = '0;
`endif

  // Counter: write beats decrement; floor at the expiry value, never wraps.
  always_ff @(posedge cpuclk or posedge cpurst) begin
    if (cpurst)                 cnt <= '0;
    else if (bus.trace_cnt_wen) cnt <= bus.trace_cnt_wdata;
    else if (take)              cnt <= expire ? expire_val : cnt - CNT_WIDTH'(1);
  end

  // Control FSM with registered request output; trace_en low forces IDLE.
  always_ff @(posedge cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state <= IDLE;
      req_q <= 1'b0;
    end else if (!bus.trace_en) begin
      state <= IDLE;
      req_q <= 1'b0;
    end else begin
      req_q <= 1'b0;
      case (state)
        IDLE:  if (!bus.iu_yy_xx_dbgon) state <= COUNT;
        COUNT: begin
          if (bus.iu_yy_xx_dbgon) begin
            state <= DBG;
          end else if (expire) begin
            state <= REQ;
            req_q <= 1'b1;
          end
        end
        REQ: begin
          if (bus.iu_yy_xx_dbgon) state <= DBG;
          else                    req_q <= 1'b1;
        end
        DBG:   if (!bus.iu_yy_xx_dbgon) state <= COUNT;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.trace_dbg_req   = req_q;
  assign bus.trace_cnt_value = cnt;
  assign bus.trace_cnt_zero  = (cnt == '0);

endmodule

// File: tb/tb_had_trace_cnt.sv
// Bench for had_trace_cnt: table of per-cycle vectors with expected
// outputs queued at drive time and popped after the clock edge, plus
// hand sequences for asynchronous reset and auto-reload.
module tb_had_trace_cnt;

`ifdef HAD_TRACE_AUTO_RELOAD_EN
  localparam bit RELOAD = 1'b1;
`else
  localparam bit RELOAD = 1'b0;
`endif

  typedef struct {
    logic       en, wen;
    logic [7:0] wd;
    logic       ret, dbg;
    logic       req;
    logic [7:0] val;
    logic       zero;
  } vec_t;

  logic cpuclk = 1'b0;
  logic cpurst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  vec_t       tbl[$];
  logic [9:0] exp_q[$];

  had_trace_cnt_if #(.CNT_WIDTH(8)) bus();

  had_trace_cnt #(.CNT_WIDTH(8)) dut (
    .cpuclk (cpuclk),
    .cpurst (cpurst),
    .bus    (bus)
  );

  always #5 cpuclk = ~cpuclk;

  task automatic add(input logic en, wen, input logic [7:0] wd,
                     input logic ret, dbg, req, input logic [7:0] val);
    vec_t v;
    v.en = en; v.wen = wen; v.wd = wd; v.ret = ret; v.dbg = dbg;
    v.req = req; v.val = val; v.zero = (val == 8'd0);
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got req=%b val=%0d zero=%b, want req=%b val=%0d zero=%b",
                  name, act[9], act[8:1], act[0], exp[9], exp[8:1], exp[0]);
  endtask

  function automatic logic [9:0] outs();
    return {bus.trace_dbg_req, bus.trace_cnt_value, bus.trace_cnt_zero};
  endfunction

  // Drive one cycle at the negedge, queue its expectation, compare after the edge.
  task automatic step(input vec_t v, input string name);
    @(negedge cpuclk);
    bus.trace_en         = v.en;
    bus.trace_cnt_wen    = v.wen;
    bus.trace_cnt_wdata  = v.wd;
    bus.trace_retire_vld = v.ret;
    bus.iu_yy_xx_dbgon   = v.dbg;
    exp_q.push_back({v.req, v.val, v.zero});
    @(posedge cpuclk);
    #1;
    chk(name, outs(), exp_q.pop_front());
  endtask

  task automatic cyc(input logic en, wen, input logic [7:0] wd,
                     input logic ret, dbg, req, input logic [7:0] val, input string name);
    vec_t v;
    v.en = en; v.wen = wen; v.wd = wd; v.ret = ret; v.dbg = dbg;
    v.req = req; v.val = val; v.zero = (val == 8'd0);
    step(v, name);
  endtask

  localparam logic [7:0] R3 = RELOAD ? 8'd3 : 8'd0;
  localparam logic [7:0] R1 = RELOAD ? 8'd1 : 8'd0;

  initial begin
    bus.trace_en = 0; bus.trace_cnt_wen = 0; bus.trace_cnt_wdata = 0;
    bus.trace_retire_vld = 0; bus.iu_yy_xx_dbgon = 0;

    //   en wen wd    ret dbg req val
    // count 3 down to expiry, ack via dbgon
    add(1, 0, 8'd0,  0, 0, 0, 8'd0);   // IDLE -> COUNT
    add(1, 1, 8'd3,  0, 0, 0, 8'd3);
    add(1, 0, 8'd0,  1, 0, 0, 8'd2);
    add(1, 0, 8'd0,  0, 0, 0, 8'd2);
    add(1, 0, 8'd0,  1, 0, 0, 8'd1);
    add(1, 0, 8'd0,  1, 0, 1, R3);     // expiry: request next cycle
    add(1, 0, 8'd0,  0, 0, 1, R3);     // held
    add(1, 0, 8'd0,  1, 0, 1, R3);     // retire ignored in REQ
    add(1, 0, 8'd0,  0, 1, 0, R3);     // ack -> DBG
    add(1, 0, 8'd0,  1, 1, 0, R3);     // retire ignored in DBG
    add(1, 0, 8'd0,  0, 0, 0, R3);     // -> COUNT
    // loaded 0 behaves as 1
    add(1, 1, 8'd0,  0, 0, 0, 8'd0);
    add(1, 0, 8'd0,  1, 0, 1, 8'd0);
    add(1, 0, 8'd0,  0, 1, 0, 8'd0);
    add(1, 0, 8'd0,  0, 0, 0, 8'd0);
    // write beats retire
    add(1, 1, 8'd5,  1, 0, 0, 8'd5);
    add(1, 0, 8'd0,  1, 0, 0, 8'd4);
    // external debug entry in COUNT
    add(1, 0, 8'd0,  0, 1, 0, 8'd4);
    add(1, 0, 8'd0,  1, 1, 0, 8'd4);
    add(1, 0, 8'd0,  1, 1, 0, 8'd4);
    add(1, 0, 8'd0,  0, 0, 0, 8'd4);   // -> COUNT
    add(1, 0, 8'd0,  1, 0, 0, 8'd3);
    // REQ pending with counter rewritten to 2, then trace_en drop
    add(1, 1, 8'd1,  0, 0, 0, 8'd1);
    add(1, 0, 8'd0,  1, 0, 1, R1);
    add(1, 1, 8'd2,  0, 0, 1, 8'd2);   // write in REQ keeps request
    add(0, 0, 8'd0,  0, 0, 0, 8'd2);   // -> IDLE, counter kept
    add(0, 0, 8'd0,  1, 0, 0, 8'd2);
    add(1, 0, 8'd0,  0, 0, 0, 8'd2);
    add(1, 0, 8'd0,  1, 0, 0, 8'd1);
    // write while disabled, then max value
    add(0, 1, 8'd7,  0, 0, 0, 8'd7);
    add(0, 0, 8'd0,  1, 0, 0, 8'd7);
    add(1, 0, 8'd0,  0, 0, 0, 8'd7);
    add(1, 0, 8'd0,  1, 0, 0, 8'd6);
    add(1, 1, 8'hFF, 0, 0, 0, 8'hFF);
    add(1, 0, 8'd0,  1, 0, 0, 8'hFE);

    // reset state
    #2;
    chk("reset_async", outs(), {1'b0, 8'd0, 1'b1});
    @(posedge cpuclk); #1;
    chk("reset_held", outs(), {1'b0, 8'd0, 1'b1});
    @(negedge cpuclk);
    cpurst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

`ifdef HAD_TRACE_AUTO_RELOAD_EN
    // two consecutive stops from one write of 2
    cyc(1, 1, 8'd2, 0, 0, 0, 8'd2, "rl_wr");
    cyc(1, 0, 8'd0, 1, 0, 0, 8'd1, "rl_r1");
    cyc(1, 0, 8'd0, 1, 0, 1, 8'd2, "rl_exp1");
    cyc(1, 0, 8'd0, 0, 1, 0, 8'd2, "rl_ack1");
    cyc(1, 0, 8'd0, 0, 0, 0, 8'd2, "rl_cnt");
    cyc(1, 0, 8'd0, 1, 0, 0, 8'd1, "rl_r3");
    cyc(1, 0, 8'd0, 1, 0, 1, 8'd2, "rl_exp2");
`else
    cyc(1, 1, 8'd1, 0, 0, 0, 8'd1, "rst_wr");
    cyc(1, 0, 8'd0, 1, 0, 1, 8'd0, "rst_exp");
`endif
    // asynchronous reset mid-REQ clears immediately, before any edge
    @(negedge cpuclk);
    cpurst = 1'b1;
    #1;
    chk("reset_mid_req", outs(), {1'b0, 8'd0, 1'b1});
    @(negedge cpuclk);
    cpurst = 1'b0;
    bus.trace_en = 1'b0;
    @(posedge cpuclk); #1;
    chk("post_reset_idle", outs(), {1'b0, 8'd0, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
